scope_capture_ctrl: RTL and testbench
=====================================

Name: scope_capture_ctrl

Overview:
Trigger-based capture sequencer that feeds the time-domain display RAM write port in the ck100MHz domain.
- Watches the incoming signed 8-bit audio sample stream and arms on a level/slope trigger with hysteresis.
- Writes one screen-width record (DEPTH samples, addresses 0..DEPTH-1) through enaTime/weaTime/addraTime/dinaTime.
- Then holds the record until the display signals frame completion, so the waveform is stable and tear-free.

Parameters:
DEPTH, 640, samples per capture record (one per active pixel column); addresses 0..DEPTH-1
ADDR_W, 10, width of addraTime
HYST, 8, hysteresis below trig_level required to arm (LSBs)
TIMEOUT, 4096, valid samples spent in ARM/WAIT_TRIG before auto-trigger

Ports:
ck100MHz  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; 1 = continuous capture, 0 = stop after current record
trig_en  in  1  1 = level trigger, 0 = free-run (trigger on first valid sample)
trig_level  in  8  signed trigger threshold
sample_valid  in  1  one-cycle strobe: sample holds new data
sample  in  8  signed two's-complement audio sample
frame_sync  in  1  one-cycle pulse, end of displayed frame (already synchronised to ck100MHz)
enaTime  out  1  RAM port-A enable
weaTime  out  1  RAM port-A write enable
addraTime  out  ADDR_W  RAM port-A address
dinaTime  out  8  RAM port-A data
busy  out  1  state != IDLE
auto_trig  out  1  1 = last record started by timeout, not by trigger
capture_done  out  1  one-cycle pulse when last record word written

Behaviour:
- Clock/reset: one clock, ck100MHz; reset synchronous, active-high, dominates all other inputs.
- Reset values: all outputs 0; state IDLE; sample counter, address and timeout counter 0.
- States: IDLE, ARM, WAIT_TRIG, CAPTURE, HOLD.
- IDLE: when run=1, go to ARM next cycle.
- ARM:
  - Clear timeout counter on entry.
  - On a valid sample <= arm_thr, go to WAIT_TRIG.
  - arm_thr = trig_level - HYST, computed 9-bit signed, saturated to -128.
  - If trig_en=0, any valid sample triggers directly; treat it as the trigger sample.
- WAIT_TRIG: a valid sample >= trig_level (signed compare) is the trigger sample.
- Timeout:
  - The timeout counter increments on each valid sample in ARM and WAIT_TRIG.
  - When the count reaches TIMEOUT-1, the current valid sample becomes the trigger sample and auto_trig is set to 1.
  - A normal trigger clears auto_trig.
- Trigger sample:
  - Written at address 0; state moves to CAPTURE.
  - Each subsequent valid sample in CAPTURE is written at address+1.
- Write timing:
  - enaTime=weaTime=1 for exactly one cycle, registered, in the cycle after the accepting sample_valid (latency 1).
  - dinaTime equals the accepted sample; addraTime holds its value between writes.
- End of record: the write at address DEPTH-1 pulses capture_done in the same cycle as its weaTime, and the state moves to HOLD. Addresses never wrap within a record.
- HOLD: ignores samples. On frame_sync, go to ARM if run=1, otherwise IDLE.
- frame_sync outside HOLD is ignored; a frame_sync in the same cycle HOLD is entered is not counted.
- run=0 mid-record: the record completes normally; the block stops at the HOLD→IDLE transition.
- Input changes mid-record: trig_level/trig_en are sampled only in ARM/WAIT_TRIG.
- sample_valid on consecutive cycles is supported (full throughput, one write per cycle).
- Reset mid-CAPTURE: weaTime drops in the next cycle; the partial record stays in RAM and is overwritten by the next capture.

Optional Feature:
Macro: SCOPE_DECIM_EN.
- Defined:
  - Adds input port decim [3:0].
  - In CAPTURE, only every (decim+1)-th valid sample after the trigger sample is written; the decimation counter resets on trigger.
  - decim=0 behaves identically to the macro undefined.
  - Trigger detection and timeout always use every valid sample.
- Undefined: no decim port; every valid sample in CAPTURE is written.

Test Plan:
- Trigger and capture: reset, run=1, trig_en=1, trig_level=0; ramp samples -20..+20 with sample_valid every 4 cycles -> arm at -8; first write addr 0 with din 0x00; 640 writes at addr 0..639 incrementing; capture_done with addr 639; busy=1; auto_trig=0.
- Hysteresis: trig_level=10, samples oscillate 5..12 (never <=2) -> no write until TIMEOUT (4096th valid sample) -> auto-trigger write at addr 0 with auto_trig=1.
- Free-run back-to-back: trig_en=0, sample_valid every cycle -> first sample at addr 0, 640 consecutive write cycles; HOLD until frame_sync pulse; next record starts on first valid after frame_sync.
- Run drop: deassert run at addr 300 -> writes continue to addr 639; after frame_sync, IDLE with busy=0 and no further writes.
- Reset mid-capture: assert reset at addr 100 -> next cycle all outputs 0; after release with run=1 -> fresh capture starts at addr 0.
- With SCOPE_DECIM_EN, decim=3: 2560 valid samples post-trigger -> 640 writes carrying every 4th sample (trigger, +4, +8, ...).

Source files
------------

// File: rtl/scope_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scope_capture_ctrl                                              |
// | Purpose  : Trigger-based capture sequencer for the time-domain display     |
// |            RAM write port. Arms on a level/slope trigger with hysteresis,  |
// |            writes one DEPTH-sample record, then holds the record until the |
// |            display reports end of frame.                                   |
// | Ports    : ck100MHz/reset - clock, synchronous active-high reset           |
// |            run, trig_en, trig_level - capture control                      |
// |            sample_valid, sample     - signed 8-bit sample stream           |
// |            frame_sync               - end-of-frame pulse                   |
// |            enaTime/weaTime/addraTime/dinaTime - RAM port A                 |
// |            busy, auto_trig, capture_done      - status                     |
// | Options  : SCOPE_DECIM_EN adds decim[3:0]; only every (decim+1)-th valid   |
// |            sample after the trigger sample is written.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module scope_capture_ctrl #(
  parameter int DEPTH   = 640,
  parameter int ADDR_W  = 10,
  parameter int HYST    = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              ck100MHz,
  input  logic              reset,
  input  logic              run,
  input  logic              trig_en,
  input  logic [7:0]        trig_level,
  input  logic              sample_valid,
  input  logic [7:0]        sample,
  input  logic              frame_sync,
`ifdef SCOPE_DECIM_EN
  input  logic [3:0]        decim,
`endif
  output logic              enaTime,
  output logic              weaTime,
  output logic [ADDR_W-1:0] addraTime,
  output logic [7:0]        dinaTime,
  output logic              busy,
  output logic              auto_trig,
  output logic              capture_done
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_TRIG = 3'd2,
    CAPTURE   = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t            state_q;
  logic              we_q;
  logic              done_q;
  logic              auto_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        din_q;
  logic [TO_W-1:0]   tmo_q;

  // Arming threshold trig_level - HYST in 9 bits; a result below -128 is
  // clamped so the most negative sample can still arm the trigger.
  logic signed [8:0] thr9_d;
  logic signed [7:0] arm_thr_d;
  logic              arm_hit_d;
  logic              norm_trig_d;
  logic              tmo_hit_d;
  logic              take_d;
  logic [ADDR_W-1:0] addr_nxt_d;

  assign thr9_d      = $signed({trig_level[7], trig_level}) - $signed(9'(HYST));
  assign arm_thr_d   = (thr9_d[8] != thr9_d[7]) ? 8'sh80 : thr9_d[7:0];
  assign arm_hit_d   = $signed(sample) <= arm_thr_d;
  // Free-run treats any valid sample as a trigger; otherwise only an armed
  // (WAIT_TRIG) sample at or above the level qualifies.
  assign norm_trig_d = !trig_en ||
                       ((state_q == WAIT_TRIG) && ($signed(sample) >= $signed(trig_level)));
  assign tmo_hit_d   = (tmo_q == TO_W'(TIMEOUT - 1));
  assign addr_nxt_d  = addr_q + ADDR_W'(1);

`ifdef SCOPE_DECIM_EN
  logic [3:0] dec_q;
  assign take_d = (dec_q == decim);
`else
  assign take_d = 1'b1;
`endif

  always_ff @(posedge ck100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      auto_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      tmo_q   <= '0;
`ifdef SCOPE_DECIM_EN
      dec_q   <= '0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= ARM;
            tmo_q   <= '0;
          end
        end
        ARM, WAIT_TRIG: begin
          if (sample_valid) begin
            if (norm_trig_d || tmo_hit_d) begin
              // Trigger sample becomes word 0 of the record.
              addr_q <= '0;
              din_q  <= sample;
              we_q   <= 1'b1;
              auto_q <= !norm_trig_d;
`ifdef SCOPE_DECIM_EN
              dec_q  <= '0;
`endif
              if (DEPTH == 1) begin
                done_q  <= 1'b1;
                state_q <= HOLD;
              end else begin
                state_q <= CAPTURE;
              end
            end else begin
              tmo_q <= tmo_q + TO_W'(1);
              if ((state_q == ARM) && arm_hit_d) begin
                state_q <= WAIT_TRIG;
              end
            end
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
`ifdef SCOPE_DECIM_EN
            dec_q <= take_d ? 4'd0 : dec_q + 4'd1;
`endif
            if (take_d) begin
              addr_q <= addr_nxt_d;
              din_q  <= sample;
              we_q   <= 1'b1;
              if (addr_nxt_d == ADDR_W'(DEPTH - 1)) begin
                done_q  <= 1'b1;
                state_q <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (frame_sync) begin
            state_q <= run ? ARM : IDLE;
            tmo_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enaTime      = we_q;
  assign weaTime      = we_q;
  assign addraTime    = addr_q;
  assign dinaTime     = din_q;
  assign capture_done = done_q;
  assign auto_trig    = auto_q;
  assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_scope_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_scope_capture_ctrl                                           |
// | Purpose  : Directed, table-driven bench for scope_capture_ctrl.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_scope_capture_ctrl;

  localparam int DEPTH = 640;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          ten = 1'b1;
  logic [7:0]    lvl = 8'h00;
  logic          vld = 1'b0;
  logic [7:0]    smp = 8'h00;
  logic          fs  = 1'b0;
`ifdef SCOPE_DECIM_EN
  logic [3:0]    decim = 4'd0;
`endif
  logic          enaTime, weaTime, busy, auto_trig, capture_done;
  logic [AW-1:0] addraTime;
  logic [7:0]    dinaTime;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scope_capture_ctrl dut (
    .ck100MHz     (clk),
    .reset        (rst),
    .run          (run),
    .trig_en      (ten),
    .trig_level   (lvl),
    .sample_valid (vld),
    .sample       (smp),
    .frame_sync   (fs),
`ifdef SCOPE_DECIM_EN
    .decim        (decim),
`endif
    .enaTime      (enaTime),
    .weaTime      (weaTime),
    .addraTime    (addraTime),
    .dinaTime     (dinaTime),
    .busy         (busy),
    .auto_trig    (auto_trig),
    .capture_done (capture_done)
  );

  typedef struct {
    logic       rst, run, ten;
    logic [7:0] lvl;
    logic       vld;
    logic [7:0] smp;
    logic       fs;
    logic       e_we;
    int         e_addr;
    logic [7:0] e_din;
    logic       e_done, e_busy, e_auto;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int a);
    logic [31:0] t;
    t = a;
    return t[7:0] ^ 8'hA5;
  endfunction

  // Data is compared only on write cycles, or when chk_din forces it.
  task automatic chk(input string nm, input logic e_we, input int e_addr,
                     input logic [7:0] e_din, input logic e_done,
                     input logic e_busy, input logic e_auto, input logic chk_din);
    logic [AW-1:0] ea;
    logic          bad;
    ea  = AW'(e_addr);
    bad = (enaTime !== e_we) || (weaTime !== e_we) || (addraTime !== ea) ||
          (capture_done !== e_done) || (busy !== e_busy) || (auto_trig !== e_auto) ||
          ((e_we || chk_din) && (dinaTime !== e_din));
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got ena=%0b we=%0b addr=%0d din=%02h done=%0b busy=%0b auto=%0b, expected we=%0b addr=%0d din=%02h done=%0b busy=%0b auto=%0b",
               nm, enaTime, weaTime, addraTime, dinaTime, capture_done, busy, auto_trig,
               e_we, e_addr, e_din, e_done, e_busy, e_auto);
    end
  endtask

  // Writes addresses a0..a1 with pattern data, 'gap' idle cycles before each.
  task automatic feed(input int a0, input int a1, input int gap, input logic e_auto);
    for (int a = a0; a <= a1; a++) begin
      for (int g = 0; g < gap; g++) begin
        vld = 1'b0;
        tick();
        chk("gap", 1'b0, a - 1, 8'h00, 1'b0, 1'b1, e_auto, 1'b0);
      end
      vld = 1'b1;
      smp = pat(a);
      tick();
      vld = 1'b0;
      chk("write", 1'b1, a, pat(a), (a == DEPTH - 1), 1'b1, e_auto, 1'b0);
    end
  endtask

  initial begin
    int nw;
    // rst run ten lvl vld smp fs | we addr din done busy auto
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'hF8, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h32, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h07, 1'b0, 1'b1, 1, 8'h07, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'hFD, 1'b0, 1'b1, 2, 8'hFD, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h64, 1'b1, 8'h09, 1'b0, 1'b1, 3, 8'h09, 1'b0, 1'b1, 1'b0};

    // Reset, arm at -8, trigger at 0, first writes; mid-record input changes ignored.
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; run = tbl[i].run; ten = tbl[i].ten; lvl = tbl[i].lvl;
      vld = tbl[i].vld; smp = tbl[i].smp; fs  = tbl[i].fs;
      tick();
      chk($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_addr, tbl[i].e_din,
          tbl[i].e_done, tbl[i].e_busy, tbl[i].e_auto, tbl[i].rst);
    end
    fs = 1'b0; ten = 1'b1; lvl = 8'h00;

    // Rest of record with sparse samples; frame_sync on the last write is ignored.
    feed(4, DEPTH - 2, 3, 1'b0);
    vld = 1'b1; smp = pat(DEPTH - 1); fs = 1'b1;
    tick();
    vld = 1'b0; fs = 1'b0;
    chk("last_write", 1'b1, DEPTH - 1, pat(DEPTH - 1), 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("hold_after_done", 1'b0, DEPTH - 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; smp = 8'h40;
      tick();
      chk("hold_ignores", 1'b0, DEPTH - 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Free-run back-to-back; run dropped at address 300.
    vld = 1'b0; ten = 1'b0; fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("hold_to_arm", 1'b0, DEPTH - 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    feed(0, 299, 0, 1'b0);
    run = 1'b0;
    feed(300, DEPTH - 1, 0, 1'b0);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("hold_to_idle", 1'b0, DEPTH - 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; smp = 8'h11;
      tick();
      chk("idle_no_write", 1'b0, DEPTH - 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Hysteresis never satisfied: auto-trigger on the 4096th valid sample.
    vld = 1'b0; run = 1'b1; ten = 1'b1; lvl = 8'd10;
    tick();
    chk("timeout_arm", 1'b0, DEPTH - 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    nw = 0;
    for (int k = 0; k < 4095; k++) begin
      vld = 1'b1; smp = 8'(5 + (k % 8));
      tick();
      if (weaTime) nw++;
    end
    n_tests++;
    if (nw != 0) begin
      n_fail++;
      $display("FAIL pre_timeout_writes: got %0d, expected 0", nw);
    end
    smp = 8'd12;
    tick();
    vld = 1'b0;
    chk("auto_trigger", 1'b1, 0, 8'h0C, 1'b0, 1'b1, 1'b1, 1'b0);
    feed(1, DEPTH - 1, 0, 1'b1);

    // Normal trigger clears auto_trig; then reset mid-capture.
    ten = 1'b0; fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("rearm_auto_kept", 1'b0, DEPTH - 1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    feed(0, 100, 0, 1'b0);
    rst = 1'b1; vld = 1'b1; smp = 8'h77;
    tick();
    chk("reset_mid_capture", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0; vld = 1'b0;
    tick();
    chk("post_reset_arm", 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    vld = 1'b1; smp = 8'h33;
    tick();
    vld = 1'b0;
    chk("post_reset_write", 1'b1, 0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);

    // Saturated arming threshold: level -125 arms only at -128.
    rst = 1'b1;
    tick();
    rst = 1'b0; lvl = 8'h83; ten = 1'b1;
    tick();
    vld = 1'b1; smp = 8'h81;
    tick();
    chk("sat_no_arm", 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    smp = 8'h83;
    tick();
    chk("sat_unarmed_level", 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    smp = 8'h80;
    tick();
    smp = 8'h82;
    tick();
    chk("sat_below_level", 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    smp = 8'h83;
    tick();
    vld = 1'b0;
    chk("sat_trigger", 1'b1, 0, 8'h83, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
